// File: rtl/mc_controller.sv
// Multicycle ARM-subset control FSM: state sequencing, datapath selects, condition and flag tracking.
// Optional macro MC_MEM_READY_EN replaces the MEM_LAT wait counter with a mem_ready handshake.
module mc_controller #(
    parameter int MEM_LAT  = 0,
    parameter int ALUCTL_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:12]        Instr,
    input  logic [3:0]          ALUFlags,
`ifdef MC_MEM_READY_EN
    input  logic                mem_ready,
`endif
    output logic                PCWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                MemWrite,
    output logic                AdrSrc,
    output logic                ALUSrcA,
    output logic [1:0]          RegSrc,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ResultSrc,
    output logic [1:0]          ImmSrc,
    output logic [ALUCTL_W-1:0] ALUControl,
    output logic [3:0]          State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB  = 4'd4,
        MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
    } state_t;

    state_t     state;
    logic [3:0] flags;
    logic       condexr;
    logic       last;
    logic       wait_state;
    logic [1:0] op;
    logic [3:0] funct;
    logic [2:0] alu_op;
    logic       op_known;
    logic       arith;
    logic       nowrite;
    logic       nextpc, branch, regw, memw, irw, regwrite_i;
    logic       unused_instr;

    assign op           = Instr[27:26];
    assign funct        = Instr[24:21];
    assign unused_instr = ^Instr[19:16];
    assign wait_state   = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    assign State        = state;

`ifdef MC_MEM_READY_EN
    assign last = mem_ready;
`else
    logic [2:0] waitcnt;
    assign last = (waitcnt == 3'(MEM_LAT));
`endif

    function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: cond_true = z;
            4'h1: cond_true = ~z;
            4'h2: cond_true = cy;
            4'h3: cond_true = ~cy;
            4'h4: cond_true = n;
            4'h5: cond_true = ~n;
            4'h6: cond_true = v;
            4'h7: cond_true = ~v;
            4'h8: cond_true = cy & ~z;
            4'h9: cond_true = ~cy | z;
            4'hA: cond_true = (n == v);
            4'hB: cond_true = (n != v);
            4'hC: cond_true = ~z & (n == v);
            4'hD: cond_true = z | (n != v);
            4'hE: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    endfunction

    // Unrecognised data-processing codes fall back to ADD with no register or flag write.
    always_comb begin
        alu_op   = 3'd0;
        op_known = 1'b1;
        arith    = 1'b0;
        case (funct)
            4'b0100:          arith = 1'b1;
            4'b0010, 4'b1010: begin alu_op = 3'd1; arith = 1'b1; end
            4'b0000, 4'b1000: alu_op = 3'd2;
            4'b1100:          alu_op = 3'd3;
            4'b0001:          if (ALUCTL_W == 4) alu_op = 3'd4; else op_known = 1'b0;
            4'b1101:          if (ALUCTL_W == 4) alu_op = 3'd5; else op_known = 1'b0;
            default:          op_known = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            flags   <= 4'b0000;
            condexr <= 1'b0;
`ifndef MC_MEM_READY_EN
            waitcnt <= 3'd0;
`endif
        end else begin
`ifndef MC_MEM_READY_EN
            waitcnt <= (wait_state && !last) ? waitcnt + 3'd1 : 3'd0;
`endif
            case (state)
                FETCH:  if (last) state <= DECODE;
                DECODE: begin
                    condexr <= cond_true(Instr[31:28], flags);
                    case (op)
                        2'b01:   state <= MEMADR;
                        2'b00:   state <= Instr[25] ? EXECI : EXECR;
                        2'b10:   state <= BRANCH;
                        default: state <= FETCH;
                    endcase
                end
                MEMADR: state <= Instr[20] ? MEMRD : MEMWR;
                MEMRD:  if (last) state <= MEMWB;
                MEMWR:  if (last) state <= FETCH;
                EXECR, EXECI: state <= ALUWB;
                ALUWB: begin
                    state <= FETCH;
                    if (condexr && Instr[20] && op_known) begin
                        flags[3:2] <= ALUFlags[3:2];
                        if (arith) flags[1:0] <= ALUFlags[1:0];
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        nextpc    = 1'b0;
        branch    = 1'b0;
        regw      = 1'b0;
        memw      = 1'b0;
        irw       = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        case (state)
            FETCH: begin
                ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
                irw = last; nextpc = last;
            end
            DECODE:        begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
            MEMADR, EXECI: ALUSrcB = 2'b01;
            MEMRD:         AdrSrc = 1'b1;
            MEMWR:         begin AdrSrc = 1'b1; memw = last; end
            MEMWB:         begin ResultSrc = 2'b01; regw = 1'b1; end
            ALUWB:         regw = op_known;
            BRANCH:        begin ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1; end
            default:       ;
        endcase
    end

    assign nowrite    = (op == 2'b00) && (funct == 4'b1010 || funct == 4'b1000);
    assign regwrite_i = regw & condexr & ~nowrite;
    // Write strobes are forced low while reset is held so nothing commits mid-reset.
    assign RegWrite   = ~reset & regwrite_i;
    assign MemWrite   = ~reset & memw & condexr;
    assign IRWrite    = ~reset & irw;
    assign PCWrite    = ~reset & (nextpc | (branch & condexr) |
                                  (regwrite_i & (Instr[15:12] == 4'hF)));
    assign ImmSrc     = op;
    assign RegSrc     = {op == 2'b01, op == 2'b10};
    assign ALUControl = (state == EXECR || state == EXECI || state == ALUWB) ?
                        ALUCTL_W'(alu_op) : '0;

endmodule

// File: tb/tb_mc_controller.sv
// Directed table-driven bench for mc_controller: one instance with MEM_LAT=0, one with MEM_LAT=2.
module tb_mc_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic [3:0]  aluflags = 4'h0;
`ifdef MC_MEM_READY_EN
    logic        mem_ready = 1'b1;
`endif

    logic       pcw0, irw0, rw0, mw0, adr0, asa0;
    logic [1:0] rs0, asb0, res0, imm0;
    logic [3:0] alu0, st0;
    logic       pcw2, irw2, rw2, mw2, adr2, asa2;
    logic [1:0] rs2, asb2, res2, imm2, alu2;
    logic [3:0] st2;

    mc_controller #(.MEM_LAT(0), .ALUCTL_W(4)) u0 (
        .clk(clk), .reset(reset), .Instr(instr[31:12]), .ALUFlags(aluflags),
`ifdef MC_MEM_READY_EN
        .mem_ready(mem_ready),
`endif
        .PCWrite(pcw0), .IRWrite(irw0), .RegWrite(rw0), .MemWrite(mw0), .AdrSrc(adr0),
        .ALUSrcA(asa0), .RegSrc(rs0), .ALUSrcB(asb0), .ResultSrc(res0), .ImmSrc(imm0),
        .ALUControl(alu0), .State(st0));

    mc_controller #(.MEM_LAT(2), .ALUCTL_W(2)) u2 (
        .clk(clk), .reset(reset), .Instr(instr[31:12]), .ALUFlags(aluflags),
`ifdef MC_MEM_READY_EN
        .mem_ready(mem_ready),
`endif
        .PCWrite(pcw2), .IRWrite(irw2), .RegWrite(rw2), .MemWrite(mw2), .AdrSrc(adr2),
        .ALUSrcA(asa2), .RegSrc(rs2), .ALUSrcB(asb2), .ResultSrc(res2), .ImmSrc(imm2),
        .ALUControl(alu2), .State(st2));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  fl;
        logic [3:0]  st;
        logic [3:0]  strb;   // {PCWrite, IRWrite, RegWrite, MemWrite}
        logic [3:0]  alu;
    } vec_t;
    vec_t vecs[$];

    localparam logic [31:0] LDR = 32'hE5910004;
    localparam logic [31:0] BEQ = 32'h0A000002;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic [3:0] fl);
        @(negedge clk);
        reset = 1'b0; instr = ins; aluflags = fl;
        #1;
    endtask

    task automatic drive_rst(input logic [31:0] ins);
        @(negedge clk);
        reset = 1'b1; instr = ins; aluflags = 4'h0;
        #1;
    endtask

    task automatic push(input logic [31:0] ins, input logic [3:0] fl, input logic [3:0] st,
                        input logic [3:0] strb, input logic [3:0] alu);
        vec_t v;
        v.ins = ins; v.fl = fl; v.st = st; v.strb = strb; v.alu = alu;
        vecs.push_back(v);
    endtask

    task automatic dp(input logic [31:0] ins, input logic [3:0] fl, input bit imm,
                      input logic [3:0] alu, input logic [3:0] wb);
        push(ins, 4'h0, 4'd0, 4'b1100, 4'd0);
        push(ins, 4'h0, 4'd1, 4'b0000, 4'd0);
        push(ins, 4'h0, imm ? 4'd7 : 4'd6, 4'b0000, alu);
        push(ins, fl, 4'd8, wb, alu);
    endtask

    task automatic br(input logic [31:0] ins, input logic pcw);
        push(ins, 4'h0, 4'd0, 4'b1100, 4'd0);
        push(ins, 4'h0, 4'd1, 4'b0000, 4'd0);
        push(ins, 4'h0, 4'd9, {pcw, 3'b000}, 4'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_st[10];
        logic [3:0] exp_sb[10];

        dp(32'hE0821003, 4'h0, 1'b0, 4'd0, 4'b0010);   // ADD R1,R2,R3
        dp(32'hE2500001, 4'b0100, 1'b1, 4'd1, 4'b0010); // SUBS R0,R0,#1 -> Z
        br(32'h0A000002, 1'b1);                          // BEQ taken
        br(32'h1A000002, 1'b0);                          // BNE not taken
        push(32'h15801000, 4'h0, 4'd0, 4'b1100, 4'd0);   // STRNE with Z=1
        push(32'h15801000, 4'h0, 4'd1, 4'b0000, 4'd0);
        push(32'h15801000, 4'h0, 4'd2, 4'b0000, 4'd0);
        push(32'h15801000, 4'h0, 4'd5, 4'b0000, 4'd0);
        push(LDR, 4'h0, 4'd0, 4'b1100, 4'd0);
        push(LDR, 4'h0, 4'd1, 4'b0000, 4'd0);
        push(LDR, 4'h0, 4'd2, 4'b0000, 4'd0);
        push(LDR, 4'h0, 4'd3, 4'b0000, 4'd0);
        push(LDR, 4'h0, 4'd4, 4'b0010, 4'd0);
        dp(32'hE3500000, 4'b1000, 1'b1, 4'd1, 4'b0000); // CMP: no reg write, N=1
        br(32'h4A000000, 1'b1);                          // BMI taken
        br(32'hAA000000, 1'b0);                          // BGE not taken
        dp(32'hE0121003, 4'b0111, 1'b0, 4'd2, 4'b0010); // ANDS: N,Z only
        br(32'h2A000000, 1'b0);                          // BCS: C must still be 0
        br(32'h0A000002, 1'b1);                          // BEQ taken
        dp(32'hE082F003, 4'h0, 1'b0, 4'd0, 4'b1010);    // ADD PC -> PCWrite
        dp(32'hE0221003, 4'h0, 1'b0, 4'd4, 4'b0010);    // EOR
        dp(32'hE1A01003, 4'h0, 1'b0, 4'd5, 4'b0010);    // MOV
        dp(32'hE1821003, 4'h0, 1'b0, 4'd3, 4'b0010);    // ORR
        dp(32'hE0E21003, 4'h0, 1'b0, 4'd0, 4'b0000);    // unsupported code
        push(32'hEC000000, 4'h0, 4'd0, 4'b1100, 4'd0);   // Op=11 back to FETCH
        push(32'hEC000000, 4'h0, 4'd1, 4'b0000, 4'd0);
        push(32'hEC000000, 4'h0, 4'd0, 4'b1100, 4'd0);

        drive_rst(32'h0);
        drive_rst(32'h0);
        chk("reset state u0", st0, 0);
        chk("reset strobes u0", {pcw0, irw0, rw0, mw0}, 0);
        chk("reset state u2", st2, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].ins, vecs[i].fl);
            chk($sformatf("vec%0d state", i), st0, vecs[i].st);
            chk($sformatf("vec%0d strobes", i), {pcw0, irw0, rw0, mw0}, vecs[i].strb);
            chk($sformatf("vec%0d aluctl", i), alu0, vecs[i].alu);
            chk($sformatf("vec%0d immsrc", i), imm0, vecs[i].ins[27:26]);
            chk($sformatf("vec%0d regsrc", i), rs0,
                {vecs[i].ins[27:26] == 2'b01, vecs[i].ins[27:26] == 2'b10});
            case (vecs[i].st)
                4'd0:    chk($sformatf("vec%0d fetch sel", i), {adr0, asa0, asb0, res0}, 6'b011010);
                4'd1:    chk($sformatf("vec%0d decode sel", i), {asa0, asb0, res0}, 5'b11010);
                4'd2:    chk($sformatf("vec%0d memadr sel", i), {asa0, asb0}, 3'b001);
                4'd5:    chk($sformatf("vec%0d memwr sel", i), adr0, 1);
                4'd6:    chk($sformatf("vec%0d execr sel", i), {asa0, asb0}, 3'b000);
                4'd8:    chk($sformatf("vec%0d aluwb sel", i), res0, 0);
                4'd9:    chk($sformatf("vec%0d branch sel", i), {asa0, asb0, res0}, 5'b00110);
                default: ;
            endcase
        end

`ifdef MC_MEM_READY_EN
        drive_rst(LDR);
        drive_rst(LDR);
        mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(LDR, 4'h0);
            chk($sformatf("rdy wait%0d state", k), st0, 0);
            chk($sformatf("rdy wait%0d irwrite", k), irw0, 0);
        end
        mem_ready = 1'b1;
        #1;
        chk("rdy strobes", {pcw0, irw0}, 2'b11);
        drive(LDR, 4'h0);
        chk("rdy decode u0", st0, 1);
        chk("rdy decode u2", st2, 1);
`else
        // LDR on the MEM_LAT=2 instance: 9 cycles, strobes only on last wait cycle.
        exp_st = '{0, 0, 0, 1, 2, 3, 3, 3, 4, 0};
        exp_sb = '{4'b0000, 4'b0000, 4'b1100, 4'b0000, 4'b0000,
                   4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        drive_rst(LDR);
        drive_rst(LDR);
        chk("lat2 reset state", st2, 0);
        for (int k = 0; k < 10; k++) begin
            drive(LDR, 4'h0);
            chk($sformatf("lat2 ldr%0d state", k), st2, exp_st[k]);
            chk($sformatf("lat2 ldr%0d strobes", k), {pcw2, irw2, rw2, mw2}, exp_sb[k]);
            if (exp_st[k] == 3) chk($sformatf("lat2 ldr%0d adrsrc", k), adr2, 1);
            if (exp_st[k] == 2) chk($sformatf("lat2 ldr%0d memadr sel", k), {asa2, asb2}, 3'b001);
            if (exp_st[k] == 4) begin
                chk("lat2 memwb resultsrc", res2, 1);
                chk("lat2 memwb aluctl", alu2, 0);
                chk("lat2 ldr immsrc/regsrc", {imm2, rs2}, 4'b0110);
            end
        end
        // Reach the middle of the MEMRD wait, then reset.
        for (int k = 0; k < 5; k++) drive(LDR, 4'h0);
        chk("lat2 pre-reset state", st2, 3);
        drive_rst(LDR);
        chk("mid reset state held", st2, 3);
        chk("mid reset strobes u2", {pcw2, irw2, rw2, mw2}, 0);
        chk("mid reset strobes u0", {pcw0, irw0, rw0, mw0}, 0);
        drive_rst(LDR);
        chk("after reset state u2", st2, 0);
        chk("after reset strobes u2", {pcw2, irw2, rw2, mw2}, 0);
        chk("after reset state u0", st0, 0);
        chk("after reset strobes u0", {pcw0, irw0, rw0, mw0}, 0);
        // Flags were Z=1 before reset; a BEQ afterwards must not be taken.
        drive(BEQ, 4'h0);
        chk("post rst f1 u2", {st2, pcw2, irw2}, {4'd0, 2'b00});
        chk("post rst fetch u0", {st0, pcw0, irw0}, {4'd0, 2'b11});
        drive(BEQ, 4'h0);
        chk("post rst f2 u2", {st2, pcw2, irw2}, {4'd0, 2'b00});
        drive(BEQ, 4'h0);
        chk("post rst f3 u2", {st2, pcw2, irw2}, {4'd0, 2'b11});
        chk("post rst beq u0", {st0, pcw0}, {4'd9, 1'b0});
        drive(BEQ, 4'h0);
        chk("post rst decode u2", st2, 1);
        drive(BEQ, 4'h0);
        chk("post rst beq u2", {st2, pcw2}, {4'd9, 1'b0});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
